// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_buffered
//  Description : Buffered UART transmitter. Words arrive over a valid/ready
//                handshake into a small FIFO and are serialised as
//                start / WIDTH data bits (LSB first) / STOP_BITS stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [WIDTH-1:0]              data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          signal,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ticks      = CLOCK_FREQ / BAUD_RATE;
    localparam int c_stop_ticks = STOP_BITS * c_ticks;
    // The tick counter must also cover the whole stop period in one run.
    localparam int c_cw         = $clog2(c_stop_ticks);
    localparam int c_aw         = $clog2(FIFO_DEPTH);
    localparam int c_kw         = c_aw + 1;
    localparam int c_iw         = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_cw-1:0] c_bit_reload  = c_cw'(c_ticks - 1);
    localparam logic [c_cw-1:0] c_stop_reload = c_cw'(c_stop_ticks - 1);
    localparam logic [c_iw-1:0] c_last_idx    = c_iw'(WIDTH - 1);
    localparam logic [c_kw-1:0] c_full        = c_kw'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [c_aw-1:0]  wr_ptr_q;
    logic [c_aw-1:0]  rd_ptr_q;
    logic [c_kw-1:0]  count_q;
    logic [c_kw-1:0]  count_d;

    state_t           state_q;
    logic [c_cw-1:0]  tick_q;
    logic [c_iw-1:0]  idx_q;
    logic [WIDTH-1:0] shift_q;
    logic             tx_q;

    logic             w_push;
    logic             w_pop;

    // Pop decisions use only registered state, so an empty FIFO can never
    // hand out a word in the same cycle it is written.
    assign w_push = data_valid && data_ready;
    assign w_pop  = (count_q != '0) &&
                    ((state_q == S_IDLE) || ((state_q == S_STOP) && (tick_q == '0)));

    assign data_ready = (count_q != c_full);
    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign signal     = tx_q;

    // Occupancy next-state: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO storage; contents are left in place on pop, only pointers move.
    always_ff @(posedge clock) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Frame sequencer: each state advances only when the tick counter hits 0.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (w_pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        tick_q  <= c_bit_reload;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick_q == '0) begin
                        tx_q    <= shift_q[0];
                        idx_q   <= '0;
                        tick_q  <= c_bit_reload;
                        state_q <= S_DATA;
                    end else begin
                        tick_q <= tick_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_q == '0) begin
                        if (idx_q < c_last_idx) begin
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + 1'b1;
                            tx_q    <= shift_q[1];
                            tick_q  <= c_bit_reload;
                        end else begin
                            tx_q    <= 1'b1;
                            tick_q  <= c_stop_reload;
                            state_q <= S_STOP;
                        end
                    end else begin
                        tick_q <= tick_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_q == '0) begin
                        // A queued word starts immediately: no idle gap.
                        if (w_pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            tx_q    <= 1'b0;
                            tick_q  <= c_bit_reload;
                            state_q <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        tick_q <= tick_q - 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_buffered
//  Description : Self-checking bench for uart_tx_buffered. A line monitor
//                decodes frames and compares them against a scoreboard of
//                pushed words; directed checks cover timing and corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       valid1;
    logic       valid2;
    logic       ready1;
    logic       ready2;
    logic       sig1;
    logic       sig2;
    logic       busy1;
    logic       busy2;
    logic [2:0] cnt1;
    logic [2:0] cnt2;

    always #5 clock = ~clock;

    uart_tx_buffered #(
        .CLOCK_FREQ(400), .BAUD_RATE(100), .WIDTH(8), .FIFO_DEPTH(4), .STOP_BITS(1)
    ) u_dut (
        .clock(clock), .resetn(resetn), .data(data1), .data_valid(valid1),
        .data_ready(ready1), .signal(sig1), .busy(busy1), .fifo_count(cnt1)
    );

    uart_tx_buffered #(
        .CLOCK_FREQ(400), .BAUD_RATE(100), .WIDTH(8), .FIFO_DEPTH(4), .STOP_BITS(2)
    ) u_dut2 (
        .clock(clock), .resetn(resetn), .data(data2), .data_valid(valid2),
        .data_ready(ready2), .signal(sig2), .busy(busy2), .fifo_count(cnt2)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] sb[$];
    int         gapq[$];
    bit         abort_frame = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one word to the STOP_BITS=1 instance, waiting for ready.
    task automatic push1(input logic [7:0] b);
        int n;
        n      = 0;
        data1  = b;
        valid1 = 1'b1;
        while (ready1 !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) check_value("push_timeout", ready1, 1);
        sb.push_back(b);
        @(negedge clock);
        valid1 = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy1 !== 1'b0) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check_value(tag, (n < 2000), 1);
    endtask

    // Line monitor: every frame is 40 samples; each bit must hold 4 cycles.
    initial begin : g_monitor
        int         idle;
        logic [39:0] s;
        logic [9:0]  fr;
        logic [7:0]  exp_b;
        forever begin
            idle = 0;
            @(negedge clock);
            while (sig1 !== 1'b0) begin
                idle++;
                @(negedge clock);
            end
            s[0] = sig1;
            for (int i = 1; i < 40; i++) begin
                @(negedge clock);
                s[i] = sig1;
            end
            if (abort_frame) begin
                abort_frame = 1'b0;
            end else if (sb.size() == 0) begin
                check_value("frame_unexpected", sb.size(), 1);
            end else begin
                exp_b = sb.pop_front();
                fr    = {1'b1, exp_b, 1'b0};
                gapq.push_back(idle);
                for (int b = 0; b < 10; b++) begin
                    check_value($sformatf("frame%02h_bit%0d", exp_b, b),
                                32'(s[4*b +: 4]), 32'({4{fr[b]}}));
                end
            end
        end
    end

    initial begin : g_watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : g_main
        bit ok;
        int low;
        int high;
        int n;

        resetn = 1'b0;
        valid1 = 1'b0;
        valid2 = 1'b0;
        data1  = 8'h00;
        data2  = 8'h00;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        check_value("rst_signal", sig1, 1);
        check_value("rst_ready", ready1, 1);
        check_value("rst_busy", busy1, 0);
        check_value("rst_count", cnt1, 0);
        check_value("rst_signal2", sig2, 1);

        // Single word: latency, busy span and return to idle.
        push1(8'hA5);
        ok = 1'b1;
        for (int i = 0; i < 41; i++) begin
            if (i == 0) check_value("s1_pre_start", sig1, 1);
            if (i == 1) check_value("s1_start_low", sig1, 0);
            if (busy1 !== 1'b1) ok = 1'b0;
            @(negedge clock);
        end
        check_value("s1_busy_span", ok, 1);
        check_value("s1_busy_end", busy1, 0);
        check_value("s1_idle_high", sig1, 1);
        wait_drain("s1_drain");

        // Six words offered continuously: back-pressure and back-to-back frames.
        gapq.delete();
        for (int k = 1; k <= 5; k++) push1(8'(k));
        check_value("s2_ready_full", ready1, 0);
        check_value("s2_count_full", cnt1, 4);
        push1(8'h06);
        wait_drain("s2_drain");
        check_value("s2_frames", gapq.size(), 6);
        for (int i = 1; i < gapq.size(); i++) check_value($sformatf("s2_gap%0d", i), gapq[i], 0);

        // Push while full is ignored, then accepted right after the next pop.
        push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44); push1(8'h55);
        check_value("s3_count_full", cnt1, 4);
        data1  = 8'hFF;
        valid1 = 1'b1;
        repeat (3) @(negedge clock);
        check_value("s3_full_hold", cnt1, 4);
        check_value("s3_not_ready", ready1, 0);
        push1(8'hFF);
        check_value("s3_refill", cnt1, 4);
        wait_drain("s3_drain");

        // Push and pop on the same stop-bit boundary edge.
        gapq.delete();
        push1(8'hA1); push1(8'hB2); push1(8'hC3);
        repeat (38) @(negedge clock);
        check_value("s6_pre", cnt1, 2);
        data1  = 8'hD4;
        valid1 = 1'b1;
        sb.push_back(8'hD4);
        @(negedge clock);
        valid1 = 1'b0;
        check_value("s6_post", cnt1, 2);
        check_value("s6_start", sig1, 0);
        wait_drain("s6_drain");
        for (int i = 1; i < gapq.size(); i++) check_value($sformatf("s6_gap%0d", i), gapq[i], 0);

        // Reset mid-frame discards the frame and the queued words.
        push1(8'h3C); push1(8'h5A); push1(8'h6B);
        repeat (15) @(negedge clock);
        abort_frame = 1'b1;
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check_value("s4_signal", sig1, 1);
        check_value("s4_count", cnt1, 0);
        check_value("s4_busy", busy1, 0);
        check_value("s4_ready", ready1, 1);
        sb.delete();
        ok = 1'b1;
        repeat (60) begin
            if (sig1 !== 1'b1 || busy1 !== 1'b0) ok = 1'b0;
            @(negedge clock);
        end
        check_value("s4_quiet", ok, 1);

        // Two stop bits: 36 low cycles, then 8 high before the next start.
        data2  = 8'h00;
        valid2 = 1'b1;
        @(negedge clock);
        check_value("s5_pre_start", sig2, 1);
        @(negedge clock);
        valid2 = 1'b0;
        low = 0;
        while (sig2 === 1'b0 && low < 200) begin
            low++;
            @(negedge clock);
        end
        high = 0;
        while (sig2 === 1'b1 && high < 200) begin
            high++;
            @(negedge clock);
        end
        check_value("s5_low_run", low, 36);
        check_value("s5_stop_run", high, 8);
        n = 0;
        while (busy2 !== 1'b0 && n < 200) begin
            n++;
            @(negedge clock);
        end
        check_value("s5_drain", (n < 200), 1);
        check_value("s5_idle_high", sig2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
